hall_filter: RTL and testbench

Front-end conditioning stage for one BLDC motor channel. Sits between the raw hall-sensor pins and the motor driver's hall input. Synchronizes and glitch-filters the three hall lines, flags invalid codes and illegal commutation jumps, and reports measured rotation direction and commutation period for speed feedback. Its filtered `hall` output drives the motor driver's `hall` port directly.

---
 rtl/hall_pkg.sv | 47 ++++
 rtl/hall_sync_filter.sv | 47 ++++
 rtl/hall_filter.sv | 165 ++++++++++++++++
 tb/tb_hall_filter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// hall_pkg: hall code constants, commutation successor functions and lock-state type
// shared by the hall_filter front end.
package hall_pkg;

  localparam logic [2:0] HALL_INVALID_LO = 3'b000;
  localparam logic [2:0] HALL_INVALID_HI = 3'b111;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic logic hall_is_valid(input logic [2:0] code);
    return (code != HALL_INVALID_LO) && (code != HALL_INVALID_HI);
  endfunction

  // Forward order 001->011->010->110->100->101->001; invalid codes map to 000,
  // which never equals a valid candidate.
  function automatic logic [2:0] hall_fwd_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b001:  nxt = 3'b011;
      3'b011:  nxt = 3'b010;
      3'b010:  nxt = 3'b110;
      3'b110:  nxt = 3'b100;
      3'b100:  nxt = 3'b101;
      3'b101:  nxt = 3'b001;
      default: nxt = HALL_INVALID_LO;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] hall_rev_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b011:  nxt = 3'b001;
      3'b010:  nxt = 3'b011;
      3'b110:  nxt = 3'b010;
      3'b100:  nxt = 3'b110;
      3'b101:  nxt = 3'b100;
      3'b001:  nxt = 3'b101;
      default: nxt = HALL_INVALID_LO;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hall_sync_filter.sv
// hall_sync_filter: two-flop synchronizer plus stability filter; raises accept when a
// new code has been stable for FILTER_CYCLES consecutive cycles.
module hall_sync_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] hall_raw,
  input  logic [2:0] hall,
  output logic [2:0] cand,
  output logic       accept
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] SCNT_MAX = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] SCNT_ONE = CW'(1);

  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [CW-1:0] scnt;

  // Synchronizer, candidate capture and saturating stability counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= 3'b000;
      s2   <= 3'b000;
      cand <= 3'b000;
      scnt <= {CW{1'b0}};
    end else begin
      s1 <= hall_raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        scnt <= {CW{1'b0}};
      end else if (scnt != SCNT_MAX) begin
        cand <= cand;
        scnt <= scnt + SCNT_ONE;
      end else begin
        cand <= cand;
        scnt <= scnt;
      end
    end
  end

  assign accept = (s2 == cand) && (scnt == SCNT_MAX) && (cand != hall);

endmodule

// File: rtl/hall_filter.sv
// hall_filter: filtered hall code, lock/fault tracking, direction and commutation period.
// Period measurement (period, period_valid, stall) exists only when HALL_PERIOD_EN is defined.
module hall_filter
  import hall_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int PERIOD_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              hall_raw,
  output logic [2:0]              hall,
  output logic                    hall_edge,
  output logic                    hall_fault,
  output logic                    dir_meas,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stall
);

  logic [2:0]  cand;
  logic        accept;
  lock_state_t state;
  lock_state_t state_next;
  logic [2:0]  hall_next;
  logic        jump_err;
  logic        jump_next;
  logic        dir_next;
  logic        fault_next;
  logic        new_valid;
  logic        step_fwd;
  logic        step_rev;

  hall_sync_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .hall_raw (hall_raw),
    .hall     (hall),
    .cand     (cand),
    .accept   (accept)
  );

  // Lock FSM next state, transition classification and fault decode.
  always_comb begin
    state_next = state;
    hall_next  = hall;
    jump_next  = jump_err;
    dir_next   = dir_meas;
    new_valid  = hall_is_valid(cand);
    step_fwd   = (hall_fwd_next(hall) == cand);
    step_rev   = (hall_rev_next(hall) == cand);
    if (accept) begin
      hall_next = cand;
      case (state)
        UNLOCKED: begin
          jump_next = 1'b0;
          if (new_valid) begin
            state_next = LOCKED;
          end else begin
            state_next = UNLOCKED;
          end
        end
        LOCKED: begin
          if (!new_valid) begin
            state_next = UNLOCKED;
          end else if (step_fwd) begin
            dir_next  = 1'b1;
            jump_next = 1'b0;
          end else if (step_rev) begin
            dir_next  = 1'b0;
            jump_next = 1'b0;
          end else begin
            jump_next = 1'b1;
          end
        end
        default: state_next = UNLOCKED;
      endcase
    end else begin
      hall_next = hall;
    end
    fault_next = !hall_is_valid(hall_next) || jump_next;
  end

  // Lock state and registered hall-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= UNLOCKED;
      hall       <= 3'b000;
      hall_edge  <= 1'b0;
      hall_fault <= 1'b1;
      dir_meas   <= 1'b0;
      jump_err   <= 1'b0;
    end else begin
      state      <= state_next;
      hall       <= hall_next;
      hall_edge  <= accept;
      hall_fault <= fault_next;
      dir_meas   <= dir_next;
      jump_err   <= jump_next;
    end
  end

`ifdef HALL_PERIOD_EN
  localparam logic [PERIOD_WIDTH-1:0] PCNT_MAX = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] PCNT_ONE = PERIOD_WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] pcnt;
  logic [PERIOD_WIDTH-1:0] pcnt_next;
  logic                    armed;
  logic                    armed_next;
  logic                    valid_next;
  logic                    lock_edge;
  logic                    step_legal;

  // armed marks one clean edge seen; a second clean edge makes the period valid.
  always_comb begin
    lock_edge  = accept && (state == UNLOCKED) && new_valid;
    step_legal = accept && (state == LOCKED) && new_valid && (step_fwd || step_rev);
    if (accept) begin
      pcnt_next = PCNT_ONE;
    end else if (pcnt != PCNT_MAX) begin
      pcnt_next = pcnt + PCNT_ONE;
    end else begin
      pcnt_next = pcnt;
    end
    if (lock_edge) begin
      armed_next = 1'b1;
      valid_next = 1'b0;
    end else if (step_legal) begin
      armed_next = 1'b1;
      valid_next = armed;
    end else if (accept || (pcnt_next == PCNT_MAX)) begin
      armed_next = 1'b0;
      valid_next = 1'b0;
    end else begin
      armed_next = armed;
      valid_next = period_valid;
    end
  end

  // Period counter and registered period outputs; an edge wins over saturation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcnt         <= {PERIOD_WIDTH{1'b0}};
      period       <= {PERIOD_WIDTH{1'b0}};
      period_valid <= 1'b0;
      stall        <= 1'b0;
      armed        <= 1'b0;
    end else begin
      pcnt         <= pcnt_next;
      period       <= accept ? pcnt : period;
      period_valid <= valid_next;
      stall        <= (pcnt_next == PCNT_MAX);
      armed        <= armed_next;
    end
  end
`else
  assign period       = {PERIOD_WIDTH{1'b0}};
  assign period_valid = 1'b0;
  assign stall        = 1'b0;
`endif

endmodule

// File: tb/tb_hall_filter.sv
// tb_hall_filter: directed self-checking bench for hall_filter (FILTER_CYCLES=16, PERIOD_WIDTH=8);
// period expectations follow HALL_PERIOD_EN.
module tb_hall_filter;

`ifdef HALL_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [2:0] hall_raw;
  logic [2:0] hall;
  logic       hall_edge;
  logic       hall_fault;
  logic       dir_meas;
  logic [7:0] period;
  logic       period_valid;
  logic       stall;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_count = 0;

  hall_filter #(
    .FILTER_CYCLES(16),
    .PERIOD_WIDTH (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .hall_raw     (hall_raw),
    .hall         (hall),
    .hall_edge    (hall_edge),
    .hall_fault   (hall_fault),
    .dir_meas     (dir_meas),
    .period       (period),
    .period_valid (period_valid),
    .stall        (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (hall_edge) edge_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Set a new raw code at a negedge and stop just after the accepting edge.
  task automatic move(input logic [2:0] code);
    @(negedge clock);
    hall_raw = code;
    wait_edges(19);
  endtask

  initial begin
    reset    = 1'b1;
    hall_raw = 3'b000;
    wait_edges(3);
    check("rst_hall", 32'(hall), 32'd0);
    check("rst_edge", 32'(hall_edge), 32'd0);
    check("rst_fault", 32'(hall_fault), 32'd1);
    check("rst_dir", 32'(dir_meas), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_pvalid", 32'(period_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // lock onto 001: visible on the 18th edge after the sampling edge
    @(negedge clock);
    hall_raw = 3'b001;
    wait_edges(18);
    check("lat_hall_before", 32'(hall), 32'd0);
    check("lat_edge_before", 32'(hall_edge), 32'd0);
    wait_edges(1);
    check("lock_hall", 32'(hall), 32'd1);
    check("lock_edge", 32'(hall_edge), 32'd1);
    check("lock_fault", 32'(hall_fault), 32'd0);
    check("lock_dir", 32'(dir_meas), 32'd0);
    wait_edges(1);
    check("edge_pulse_end", 32'(hall_edge), 32'd0);

    // 5-cycle glitch to 011 is rejected
    @(negedge clock);
    hall_raw = 3'b011;
    repeat (5) @(negedge clock);
    hall_raw = 3'b001;
    wait_edges(30);
    check("glitch_hall", 32'(hall), 32'd1);
    check("glitch_edges", 32'(edge_count), 32'd1);

    // forward steps 200 cycles apart
    move(3'b011);
    check("f1_hall", 32'(hall), 32'd3);
    check("f1_dir", 32'(dir_meas), 32'd1);
    check("f1_pvalid", 32'(period_valid), PEN ? 32'd1 : 32'd0);
    wait_edges(181);
    move(3'b010);
    check("f2_hall", 32'(hall), 32'd2);
    check("f2_period", 32'(period), PEN ? 32'd200 : 32'd0);
    check("f2_pvalid", 32'(period_valid), PEN ? 32'd1 : 32'd0);
    check("f2_stall", 32'(stall), 32'd0);
    wait_edges(181);
    move(3'b110);
    check("f3_dir", 32'(dir_meas), 32'd1);
    check("f3_period", 32'(period), PEN ? 32'd200 : 32'd0);
    wait_edges(181);

    // reverse steps
    move(3'b010);
    check("r1_dir", 32'(dir_meas), 32'd0);
    check("r1_fault", 32'(hall_fault), 32'd0);
    check("r1_period", 32'(period), PEN ? 32'd200 : 32'd0);
    wait_edges(181);
    move(3'b011);
    check("r2_hall", 32'(hall), 32'd3);
    check("r2_dir", 32'(dir_meas), 32'd0);
    wait_edges(181);

    // illegal jump 011 -> 100, cleared by 100 -> 101
    move(3'b100);
    check("jump_hall", 32'(hall), 32'd4);
    check("jump_fault", 32'(hall_fault), 32'd1);
    check("jump_pvalid", 32'(period_valid), 32'd0);
    check("jump_dir", 32'(dir_meas), 32'd0);
    wait_edges(181);
    check("jump_fault_held", 32'(hall_fault), 32'd1);
    move(3'b101);
    check("clr_fault", 32'(hall_fault), 32'd0);
    check("clr_dir", 32'(dir_meas), 32'd1);
    check("clr_pvalid", 32'(period_valid), 32'd0);
    wait_edges(181);
    move(3'b001);
    check("rearm_pvalid", 32'(period_valid), PEN ? 32'd1 : 32'd0);
    check("rearm_period", 32'(period), PEN ? 32'd200 : 32'd0);

    // stall: hold far beyond the 8-bit counter range
    wait_edges(300);
    check("stall_set", 32'(stall), PEN ? 32'd1 : 32'd0);
    check("stall_pvalid", 32'(period_valid), 32'd0);
    move(3'b011);
    check("stall_period", 32'(period), PEN ? 32'd255 : 32'd0);
    check("stall_clear", 32'(stall), 32'd0);
    check("stall_edge", 32'(hall_edge), 32'd1);
    check("stall_pvalid_after", 32'(period_valid), 32'd0);
    wait_edges(181);

    // invalid 111 unlocks; 010 then relocks with no jump error
    move(3'b111);
    check("inv_hall", 32'(hall), 32'd7);
    check("inv_fault", 32'(hall_fault), 32'd1);
    check("inv_pvalid", 32'(period_valid), 32'd0);
    wait_edges(181);
    move(3'b010);
    check("relock_hall", 32'(hall), 32'd2);
    check("relock_fault", 32'(hall_fault), 32'd0);
    check("relock_edge", 32'(hall_edge), 32'd1);
    wait_edges(181);
    move(3'b110);
    check("relock_dir", 32'(dir_meas), 32'd1);
    check("relock_pvalid", 32'(period_valid), PEN ? 32'd1 : 32'd0);
    check("relock_period", 32'(period), PEN ? 32'd200 : 32'd0);

    // asynchronous reset mid-operation
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_hall", 32'(hall), 32'd0);
    check("arst_fault", 32'(hall_fault), 32'd1);
    check("arst_dir", 32'(dir_meas), 32'd0);
    check("arst_period", 32'(period), 32'd0);
    check("arst_pvalid", 32'(period_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
